// File: rtl/bp_reg_initiator_if.sv
// BytePipe register-initiator bus: request, response and both BytePipe byte streams.
// The initiator uses the slave modport; whatever drives it uses master.
interface bp_reg_initiator_if;
   logic       i_req_valid;
   logic       o_req_ready;
   logic       i_req_wr;
   logic [6:0] i_req_addr;
   logic [7:0] i_req_data;
   logic       o_rsp_valid;
   logic       i_rsp_ready;
   logic [7:0] o_rsp_data;
   logic       o_rsp_timeout;
   logic [7:0] o_bp_data;
   logic       o_bp_valid;
   logic       i_bp_ready;
   logic [7:0] i_bp_data;
   logic       i_bp_valid;
   logic       o_bp_ready;

   modport slave (
      input  i_req_valid, i_req_wr, i_req_addr, i_req_data, i_rsp_ready,
             i_bp_ready, i_bp_data, i_bp_valid,
      output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_timeout,
             o_bp_data, o_bp_valid, o_bp_ready
   );

   modport master (
      output i_req_valid, i_req_wr, i_req_addr, i_req_data, i_rsp_ready,
             i_bp_ready, i_bp_data, i_bp_valid,
      input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_timeout,
             o_bp_data, o_bp_valid, o_bp_ready
   );
endinterface

// File: rtl/bp_reg_initiator.sv
// BytePipe register-access initiator: sends a command (and data) byte for each
// request, then returns the single response byte or a timeout indication.
module bp_reg_initiator #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_cg,
   bp_reg_initiator_if.slave bus
);
   localparam int unsigned      CNT_W    = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_DATA,
      ST_WAIT,
      ST_RSP
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wr_q, wr_d;
   logic [7:0]       wdata_q, wdata_d;
   logic [7:0]       bp_data_q, bp_data_d;
   logic [7:0]       rsp_data_q, rsp_data_d;
   logic             rsp_timeout_q, rsp_timeout_d;
   logic             req_ready, rsp_valid, bp_valid, bp_ready;

   // Clock gate freezes every flop; reset still applies while gated.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         wr_q          <= 1'b0;
         wdata_q       <= '0;
         bp_data_q     <= '0;
         rsp_data_q    <= '0;
         rsp_timeout_q <= 1'b0;
      end else if (i_cg) begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         wr_q          <= wr_d;
         wdata_q       <= wdata_d;
         bp_data_q     <= bp_data_d;
         rsp_data_q    <= rsp_data_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      wr_d          = wr_q;
      wdata_d       = wdata_q;
      bp_data_d     = bp_data_q;
      rsp_data_d    = rsp_data_q;
      rsp_timeout_d = rsp_timeout_q;
      req_ready     = 1'b0;
      rsp_valid     = 1'b0;
      bp_valid      = 1'b0;
      bp_ready      = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            bp_ready  = 1'b1;
            if (bus.i_req_valid) begin
               wr_d      = bus.i_req_wr;
               wdata_d   = bus.i_req_data;
               bp_data_d = {bus.i_req_wr, bus.i_req_addr};
               state_d   = ST_CMD;
            end
         end
         ST_CMD: begin
            bp_valid = 1'b1;
            if (bus.i_bp_ready) begin
               if (wr_q) begin
                  bp_data_d = wdata_q;
                  state_d   = ST_DATA;
               end else begin
                  cnt_d   = '0;
                  state_d = ST_WAIT;
               end
            end
         end
         ST_DATA: begin
            bp_valid = 1'b1;
            if (bus.i_bp_ready) begin
               cnt_d   = '0;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            bp_ready = 1'b1;
            // A response byte takes priority over a timeout in the same cycle.
            if (bus.i_bp_valid) begin
               rsp_data_d    = bus.i_bp_data;
               rsp_timeout_d = 1'b0;
               state_d       = ST_RSP;
            end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
               rsp_data_d    = '0;
               rsp_timeout_d = 1'b1;
               state_d       = ST_RSP;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RSP: begin
            rsp_valid = 1'b1;
            if (bus.i_rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.o_req_ready   = req_ready;
   assign bus.o_rsp_valid   = rsp_valid;
   assign bus.o_rsp_data    = rsp_data_q;
   assign bus.o_rsp_timeout = rsp_timeout_q;
   assign bus.o_bp_data     = bp_data_q;
   assign bus.o_bp_valid    = bp_valid;
   assign bus.o_bp_ready    = bp_ready;
endmodule
